// File: rtl/clkx_pkg.sv
// Shared types and helpers for the digital clock multiplier: FSM states,
// the multiplier ceiling and the period tolerance comparison.
package clkx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_e;

    localparam int MULT_MAX = 16;

    // True when |a - b| <= tol; operands are zero-extended to 32 bits by callers.
    function automatic logic in_tol(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] tol);
        if (a >= b) begin
            return (a - b) <= tol;
        end
        return (b - a) <= tol;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input followed by a registered
// rising-edge detector producing a single-cycle pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= din;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/clk_mult_dig.sv
// Digital clock multiplier: measures the reference period in clk_in cycles and
// regenerates MULT evenly spaced output periods per reference period.
module clk_mult_dig
    import clkx_pkg::*;
#(
    parameter int MULT     = 4,
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             ref_in,
    input  logic             en,
    output logic             clk_out,
    output logic             tick,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             overflow
);

    localparam int                MW      = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int                PH_W    = $clog2(2 * MULT_MAX);
    localparam logic [CNT_W:0]    TWO_M   = (CNT_W + 1)'(2 * MULT);
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(2 * MULT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_e            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, period_next;
    logic              overflow_next, locked_next;
    logic [MW-1:0]     match, match_next;
    logic [CNT_W:0]    acc, acc_next, sum;
    logic [PH_W-1:0]   ph, ph_next;
    logic              clk_out_next, tick_next;
    logic              ref_edge, counting, new_ok, fast_ok, gen_active;

    sync_edge_det u_sync (
        .clk   (clk_in),
        .rst_n (rst_n),
        .din   (ref_in),
        .pulse (ref_edge)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            period   <= '0;
            overflow <= 1'b0;
            match    <= '0;
            locked   <= 1'b0;
            acc      <= '0;
            ph       <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            period   <= period_next;
            overflow <= overflow_next;
            match    <= match_next;
            locked   <= locked_next;
            acc      <= acc_next;
            ph       <= ph_next;
            clk_out  <= clk_out_next;
            tick     <= tick_next;
        end
    end

    // Period measurement and lock state machine.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        period_next   = period;
        overflow_next = overflow;
        match_next    = match;
        new_ok        = in_tol(32'(cnt), 32'(period), 32'(TOL));
        fast_ok       = cnt >= CNT_W'(2 * MULT);
        counting      = (state == TRACK) || (state == LOCKED) ||
                        ((state == MEASURE) && (cnt != '0));

        if (counting && !ref_edge) begin
            if (cnt == CNT_MAX) begin
                overflow_next = 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (en) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (ref_edge) begin
                    cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt != '0) begin
                        period_next = cnt;
                        match_next  = '0;
                        state_next  = TRACK;
                    end
                end
            end
            TRACK: begin
                if (ref_edge) begin
                    period_next = cnt;
                    cnt_next    = {{(CNT_W-1){1'b0}}, 1'b1};
                    if (!new_ok) begin
                        match_next = '0;
                    end else if (match != MW'(LOCK_CNT)) begin
                        match_next = match + 1'b1;
                    end
                    // A sticky overflow keeps the block out of lock until disabled.
                    if (new_ok && (match_next == MW'(LOCK_CNT)) && fast_ok && !overflow_next) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (ref_edge) begin
                    period_next = cnt;
                    cnt_next    = {{(CNT_W-1){1'b0}}, 1'b1};
                    if (!new_ok || !fast_ok) begin
                        match_next = '0;
                        state_next = TRACK;
                    end
                end
                if (overflow_next) begin
                    match_next = '0;
                    state_next = TRACK;
                end
            end
            default: state_next = IDLE;
        endcase

        if (!en) begin
            state_next    = IDLE;
            cnt_next      = '0;
            period_next   = '0;
            overflow_next = 1'b0;
            match_next    = '0;
        end
        locked_next = (state_next == LOCKED);
    end

    // Bresenham output generator; a reference edge always overrides a toggle.
    always_comb begin
        acc_next     = acc;
        ph_next      = ph;
        clk_out_next = clk_out;
        tick_next    = 1'b0;
        sum          = acc + TWO_M;
        gen_active   = ((state_next == TRACK) || (state_next == LOCKED)) &&
                       ({1'b0, period_next} >= TWO_M);

        if (!gen_active) begin
            acc_next     = '0;
            ph_next      = '0;
            clk_out_next = 1'b0;
        end else if (ref_edge) begin
            acc_next     = '0;
            ph_next      = '0;
            clk_out_next = 1'b1;
            tick_next    = 1'b1;
        end else if (ph != PH_LAST) begin
            acc_next = sum;
            if (sum >= {1'b0, period}) begin
                acc_next     = sum - {1'b0, period};
                clk_out_next = ~clk_out;
                ph_next      = ph + 1'b1;
                tick_next    = ~clk_out;
            end
        end
    end

endmodule

// File: tb/tb_clk_mult_dig.sv
// Scenario bench for clk_mult_dig: drives reference periods, scoreboards the
// measured period and checks lock, realignment, toggle spacing and overflow.
module tb_clk_mult_dig;

    localparam int CNT_W = 8;

    logic             clk_in;
    logic             rst_n;
    logic             ref_in;
    logic             en;
    logic             clk_out;
    logic             tick;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             overflow;

    int vectors;
    int miscompares;
    int exp_q[$];
    int last_len;
    int win_togg, win_ticks, run_len, hp_min, hp_max;
    logic prev_clk;

    clk_mult_dig #(.MULT(4), .CNT_W(CNT_W), .LOCK_CNT(4), .TOL(2)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .ref_in   (ref_in),
        .en       (en),
        .clk_out  (clk_out),
        .tick     (tick),
        .locked   (locked),
        .period   (period),
        .overflow (overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // One reference period of p cycles starting with a rising edge.
    task automatic ref_cycle(input int p, input bit load, input bit exp_lock,
                             input bit exp_clk);
        int exp_p;
        win_togg  = 0;
        win_ticks = 0;
        if (load) exp_q.push_back(last_len);
        for (int i = 0; i < p; i++) begin
            ref_in = (i < p / 2);
            @(posedge clk_in);
            #1;
            if (clk_out !== prev_clk) begin
                if (run_len < hp_min) hp_min = run_len;
                if (run_len > hp_max) hp_max = run_len;
                run_len = 1;
                win_togg++;
            end else begin
                run_len++;
            end
            prev_clk = clk_out;
            if (tick === 1'b1) win_ticks++;
            if (i == 2) begin
                vectors++;
                if (clk_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL clk_before_edge p=%0d: got %b expected 0", p, clk_out);
                end
            end
            if (i == 3) begin
                if (load) begin
                    exp_p = exp_q.pop_front();
                    vectors++;
                    if (period !== CNT_W'(exp_p)) begin
                        miscompares++;
                        $display("FAIL period: got %0d expected %0d", period, exp_p);
                    end
                end
                vectors++;
                if (locked !== exp_lock) begin
                    miscompares++;
                    $display("FAIL locked p=%0d: got %b expected %b", p, locked, exp_lock);
                end
                vectors++;
                if (clk_out !== exp_clk || tick !== exp_clk) begin
                    miscompares++;
                    $display("FAIL realign p=%0d: clk_out=%b tick=%b expected %b", p, clk_out, tick, exp_clk);
                end
                vectors++;
                if (overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL overflow_quiet: got %b expected 0", overflow);
                end
            end
            if (i == 4) begin
                vectors++;
                if (tick !== 1'b0) begin
                    miscompares++;
                    $display("FAIL tick_width: got %b expected 0", tick);
                end
            end
        end
        ref_in   = 1'b0;
        last_len = p;
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({clk_out, tick, locked, overflow} !== 4'b0 || period !== '0) begin
            miscompares++;
            $display("FAIL %s: clk_out=%b tick=%b locked=%b overflow=%b period=%0d expected all 0",
                     name, clk_out, tick, locked, overflow, period);
        end
    endtask

    task automatic acquire(input int p);
        en = 1'b1;
        step(2);
        ref_cycle(p, 1'b0, 1'b0, 1'b0);
        ref_cycle(p, 1'b1, 1'b0, p >= 8);
        for (int n = 3; n <= 5; n++) ref_cycle(p, 1'b1, 1'b0, p >= 8);
        ref_cycle(p, 1'b1, p >= 8, p >= 8);
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        en     = 1'b0;
        ref_in = 1'b0;
        step(3);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        step(2);
        check_idle_outputs("idle_after_release");
    endtask

    task automatic test_lock;
        acquire(64);
        hp_min = 1000;
        hp_max = 0;
        for (int n = 0; n < 2; n++) begin
            ref_cycle(64, 1'b1, 1'b1, 1'b1);
            vectors++;
            if (win_togg != 8 || win_ticks != 4) begin
                miscompares++;
                $display("FAIL toggles64: toggles=%0d ticks=%0d expected 8 and 4", win_togg, win_ticks);
            end
        end
        vectors++;
        if (hp_min != 8 || hp_max != 8) begin
            miscompares++;
            $display("FAIL half_period64: min=%0d max=%0d expected 8 and 8", hp_min, hp_max);
        end
    endtask

    task automatic test_lock_loss;
        ref_cycle(80, 1'b1, 1'b1, 1'b1);
        ref_cycle(80, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) ref_cycle(80, 1'b1, 1'b0, 1'b1);
        ref_cycle(80, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_overflow;
        ref_in = 1'b0;
        step(300);
        vectors++;
        if (overflow !== 1'b1 || locked !== 1'b0 || period !== CNT_W'(80)) begin
            miscompares++;
            $display("FAIL overflow_set: overflow=%b locked=%b period=%0d expected 1 0 80",
                     overflow, locked, period);
        end
        step(20);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        end
        en = 1'b0;
        step(1);
        check_idle_outputs("overflow_clear_on_disable");
    endtask

    task automatic test_period70;
        acquire(70);
        hp_min = 1000;
        hp_max = 0;
        for (int n = 0; n < 2; n++) begin
            ref_cycle(70, 1'b1, 1'b1, 1'b1);
            vectors++;
            if (win_togg != 8) begin
                miscompares++;
                $display("FAIL toggles70: got %0d expected 8", win_togg);
            end
        end
        vectors++;
        if (hp_min != 8 || hp_max != 9) begin
            miscompares++;
            $display("FAIL half_period70: min=%0d max=%0d expected 8 and 9", hp_min, hp_max);
        end
    endtask

    task automatic test_async_reset;
        step(5);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset_immediate");
        #2;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        prev_clk = clk_out;
        acquire(64);
    endtask

    task automatic test_short_period;
        en = 1'b0;
        step(2);
        acquire(6);
        ref_cycle(6, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (period !== CNT_W'(6) || clk_out !== 1'b0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL short_period: period=%0d clk_out=%b locked=%b expected 6 0 0",
                     period, clk_out, locked);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_len    = 0;
        run_len     = 1;
        hp_min      = 1000;
        hp_max      = 0;
        prev_clk    = 1'b0;
        test_reset();
        test_lock();
        test_lock_loss();
        test_overflow();
        test_period70();
        test_async_reset();
        test_short_period();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
